// File: rtl/wb_arb_pkg.sv
// Shared types and default sizing for the Wishbone SDRAM-controller arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWNED, ABORT} arb_state_t;

  localparam int NUM_MASTERS_DEF    = 4;
  localparam int AW_DEF             = 26;
  localparam int DW_DEF             = 32;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate requests so last_grant+1 is bit 0,
// take the lowest set bit, rotate the one-hot result back.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last_grant,
  output logic [N-1:0] gnt
);

  localparam int IW = $clog2(N);

  logic [IW-1:0]  last_idx;
  logic [IW-1:0]  shamt;
  logic [2*N-1:0] rot_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;
  logic [2*N-1:0] back_dbl;

  always_comb begin
    last_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (last_grant[k]) last_idx = IW'(k);
    end
  end

  assign shamt    = (last_idx == IW'(N-1)) ? '0 : last_idx + 1'b1;
  assign rot_dbl  = {req, req} >> shamt;
  assign rot      = rot_dbl[N-1:0];
  assign pick     = rot & (~rot + 1'b1);
  assign back_dbl = {pick, pick} << shamt;
  assign gnt      = back_dbl[2*N-1:N];

endmodule

// File: rtl/wb_sdrc_arbiter.sv
// Round-robin Wishbone B4 classic arbiter in front of the SDRAM controller slave port.
// Optional stall watchdog with ERR/ABORT is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_sdrc_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = NUM_MASTERS_DEF,
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        busy_o
);

  localparam int SW = DW / 8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("wb_sdrc_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_t             state, state_n;
  logic [NUM_MASTERS-1:0] grant_n;
  logic [NUM_MASTERS-1:0] last_grant, last_grant_n;
  logic [NUM_MASTERS-1:0] picked;
  logic                   mux_cyc, mux_stb, mux_we;
  logic [SW-1:0]          mux_sel;
  logic [AW-1:0]          mux_adr;
  logic [DW-1:0]          mux_dat;
  logic                   live;
  logic                   abort_fire;

  rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req        (m_cyc_i),
    .last_grant (last_grant),
    .gnt        (picked)
  );

  // Granted master's request; grant_o is one-hot or zero so at most one slice wins.
  always_comb begin
    mux_cyc = 1'b0;
    mux_stb = 1'b0;
    mux_we  = 1'b0;
    mux_sel = '0;
    mux_adr = '0;
    mux_dat = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_o[k]) begin
        mux_cyc = m_cyc_i[k];
        mux_stb = m_stb_i[k];
        mux_we  = m_we_i[k];
        mux_sel = m_sel_i[k*SW +: SW];
        mux_adr = m_adr_i[k*AW +: AW];
        mux_dat = m_dat_i[k*DW +: DW];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] stall_cnt;

  assign abort_fire = (state == OWNED) && mux_stb && !s_ack_i &&
                      (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign m_err_o    = abort_fire ? grant_o : '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state != OWNED || s_ack_i || abort_fire) stall_cnt <= '0;
    else if (mux_stb) stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign abort_fire = 1'b0;
  assign m_err_o    = '0;
`endif

  assign live    = (state == OWNED) && !abort_fire;
  assign s_cyc_o = live & mux_cyc;
  assign s_stb_o = live & mux_stb;
  assign s_we_o  = live & mux_we;
  assign s_sel_o = live ? mux_sel : '0;
  assign s_adr_o = live ? mux_adr : '0;
  assign s_dat_o = live ? mux_dat : '0;
  assign m_ack_o = live ? (grant_o & m_cyc_i & m_stb_i & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_dat_o = s_dat_i;
  assign busy_o  = (state != IDLE);

  always_comb begin
    state_n      = state;
    grant_n      = grant_o;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          state_n      = OWNED;
          grant_n      = picked;
          last_grant_n = picked;
        end
      end
      OWNED: begin
        if (!mux_cyc) begin
          state_n = IDLE;
          grant_n = '0;
        end else if (abort_fire) begin
          state_n = ABORT;
        end
      end
      ABORT: begin
        if (!mux_cyc) begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      grant_o    <= '0;
      last_grant <= {1'b1, {(NUM_MASTERS-1){1'b0}}};
    end else begin
      state      <= state_n;
      grant_o    <= grant_n;
      last_grant <= last_grant_n;
    end
  end

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// Directed bench for wb_sdrc_arbiter; the bench plays the SDRAM controller slave.
// Define WB_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog path.
module tb_wb_sdrc_arbiter;

  localparam int NM = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*SW-1:0]  m_sel;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack, m_err;
  logic              s_cyc, s_stb, s_we;
  logic [SW-1:0]     s_sel;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o, s_dat_i;
  logic              s_ack;
  logic [NM-1:0]     grant;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem_word;

  always #5 clk = ~clk;

  wb_sdrc_arbiter #(
    .NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .grant_o(grant), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_we[k]  = we;
    m_sel[k*SW +: SW] = cyc ? {SW{1'b1}} : '0;
    m_adr[k*AW +: AW] = adr;
    m_dat[k*DW +: DW] = dat;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    s_dat_i = '0; s_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_ack_err", {m_ack, m_err}, 0);

    // Single-master write through master 1
    set_m(1, 1, 1, 1, 26'h000100, 32'hCAFE0001);
    chk("t1_latency_scyc", s_cyc, 0);
    tick();
    chk("t1_grant", grant, 4'b0010);
    chk("t1_busy", busy, 1);
    chk("t1_scyc_stb_we", {s_cyc, s_stb, s_we}, 3'b111);
    chk("t1_adr", s_adr, 26'h000100);
    chk("t1_dat", s_dat_o, 32'hCAFE0001);
    chk("t1_sel", s_sel, 4'hF);
    s_ack = 1'b1; #1;
    chk("t1_ack", m_ack, 4'b0010);
    tick();
    s_ack = 1'b0;
    set_m(1, 0, 0, 0, '0, '0);
    chk("t1_drop_scyc", s_cyc, 0);
    chk("t1_grant_held", grant, 4'b0010);
    tick();
    chk("t1_grant_clear", grant, 0);
    chk("t1_idle", busy, 0);

    // All four request after reset: grant order 0,1,2,3 with one idle cycle between
    do_reset();
    for (int k = 0; k < NM; k++) set_m(k, 1, 1, 0, AW'(k), '0);
    for (int k = 0; k < NM; k++) begin
      chk($sformatf("t2_idle_scyc_%0d", k), s_cyc, 0);
      tick();
      chk($sformatf("t2_grant_%0d", k), grant, 64'(1 << k));
      chk($sformatf("t2_adr_%0d", k), s_adr, 64'(k));
      s_ack = 1'b1; #1;
      chk($sformatf("t2_ack_%0d", k), m_ack, 64'(1 << k));
      tick();
      s_ack = 1'b0;
      set_m(k, 0, 0, 0, '0, '0);
      tick();
      chk($sformatf("t2_gap_grant_%0d", k), grant, 0);
    end

    // Master 2 burst of 4 beats while master 0 waits
    set_m(2, 1, 1, 0, 26'h200, '0);
    tick();
    chk("t3_grant_m2", grant, 4'b0100);
    set_m(0, 1, 1, 0, 26'h300, '0);
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1; #1;
      chk($sformatf("t3_beat_ack_%0d", b), m_ack, 4'b0100);
      tick();
      chk($sformatf("t3_hold_%0d", b), grant, 4'b0100);
    end
    s_ack = 1'b0;
    set_m(2, 0, 0, 0, '0, '0);
    tick();
    chk("t3_gap", grant, 0);
    tick();
    chk("t3_grant_m0", grant, 4'b0001);
    set_m(0, 0, 0, 0, '0, '0);
    tick();

    // Write via m2, read back via m3; the bench slave stores the written word
    set_m(2, 1, 1, 1, 26'h40, 32'h12345678);
    tick();
    chk("t4_wr_grant", grant, 4'b0100);
    chk("t4_wr_we", s_we, 1);
    mem_word = s_dat_o;
    s_ack = 1'b1; #1;
    chk("t4_wr_ack", m_ack, 4'b0100);
    tick();
    s_ack = 1'b0;
    set_m(2, 0, 0, 0, '0, '0);
    tick();
    set_m(3, 1, 1, 0, 26'h40, '0);
    tick();
    chk("t4_rd_grant", grant, 4'b1000);
    chk("t4_rd_we", s_we, 0);
    chk("t4_rd_adr", s_adr, 26'h40);
    s_dat_i = mem_word;
    s_ack = 1'b1; #1;
    chk("t4_rd_data", m_dat_o, 32'h12345678);
    chk("t4_rd_ack", m_ack, 4'b1000);
    tick();
    s_ack = 1'b0; s_dat_i = '0;
    set_m(3, 0, 0, 0, '0, '0);
    tick();

    // Reset mid-ownership
    set_m(1, 1, 1, 0, 26'h10, '0);
    tick();
    chk("t5_grant_m1", grant, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_m(1, 0, 0, 0, '0, '0);
    chk("t5_grant_clr", grant, 0);
    chk("t5_scyc_busy", {s_cyc, busy}, 0);
    set_m(0, 1, 1, 0, '0, '0);
    set_m(3, 1, 1, 0, '0, '0);
    tick();
    chk("t5_restart_m0", grant, 4'b0001);
    chk("t5_no_err", m_err, 0);
    set_m(0, 0, 0, 0, '0, '0);
    set_m(3, 0, 0, 0, '0, '0);
    tick();
    tick();
    chk("t5_idle", busy, 0);

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled slave: ERR after 16 stalled cycles, then ABORT until CYC falls
    set_m(1, 1, 1, 0, 26'h80, '0);
    tick();
    chk("t6_grant", grant, 4'b0010);
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("t6_no_err_%0d", c), m_err, 0);
      tick();
    end
    chk("t6_err", m_err, 4'b0010);
    chk("t6_scyc_drop", s_cyc, 0);
    tick();
    chk("t6_err_pulse", m_err, 0);
    chk("t6_abort_hold", {grant, busy, s_cyc}, {4'b0010, 1'b1, 1'b0});
    set_m(1, 0, 0, 0, '0, '0);
    tick();
    chk("t6_back_idle", {grant, busy}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
